// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer_pkg / fetch_inst_buffer
//
// Instruction buffer between fetch and decode. Fetch entries are kept in a
// circular FIFO. Fetch writes a group of up to ENQ_WIDTH entries per cycle,
// and decode sees up to DEQ_WIDTH in-order head entries per cycle. A
// commit-stage squash empties the buffer.
//
// Ports:
//   clk         core clock
//   rst         asynchronous reset, active-high
//   i_squash    flush all entries; same-cycle enqueue and dequeue are discarded
//   i_enq_req   per-slot write request, contiguous from bit 0
//   i_enq_inst  fetch group payload, slot 0 first
//   o_can_enq   buffer can accept a full ENQ_WIDTH group this cycle
//   o_deq_vld   head slot i is offered to decode
//   o_deq_inst  head entries, slot 0 = oldest
//   i_deq_req   decode consumes every slot with o_deq_vld set
//   o_count     current occupancy

package fetch_inst_buffer_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  ftq_idx;
    logic [2:0]  ftq_offset;
    logic        has_except;
    logic [3:0]  except;
  } fetch_entry_t;
endpackage

module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_squash,
  input  logic         [ENQ_WIDTH-1:0]          i_enq_req,
  input  fetch_entry_t [ENQ_WIDTH-1:0]          i_enq_inst,
  output logic                                  o_can_enq,
  output logic         [DEQ_WIDTH-1:0]          o_deq_vld,
  output fetch_entry_t [DEQ_WIDTH-1:0]          o_deq_inst,
  input  logic                                  i_deq_req,
  output logic         [$clog2(DEPTH):0]        o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rptr_reg;
  logic [PW-1:0] wptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  fetch_entry_t mem [DEPTH];

  logic [DEQ_WIDTH-1:0] raw_vld;
  logic [DEQ_WIDTH-1:0] deq_vld;
  fetch_entry_t [DEQ_WIDTH-1:0] head_entry;
  logic          do_enq;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;
  logic          stop_scan;

  // Space is judged from the registered count only; a same-cycle dequeue
  // does not free room for this cycle's group.
  assign o_can_enq = (count_reg <= CW'(DEPTH - ENQ_WIDTH));
  assign do_enq    = o_can_enq & ~i_squash;

  genvar gi;
  generate
    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_head
      assign head_entry[gi] = mem[rptr_reg + PW'(gi)];
      assign raw_vld[gi]    = (count_reg > CW'(gi));
    end
  endgenerate

  // Exception isolation: an excepting entry is only offered when it is the
  // oldest, and then alone; older clean entries ahead of it still go.
  always_comb begin
    deq_vld   = '0;
    stop_scan = 1'b0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (!stop_scan && raw_vld[i]) begin
        if (head_entry[i].has_except) begin
          stop_scan = 1'b1;
          if (i == 0) deq_vld[i] = 1'b1;
        end else begin
          deq_vld[i] = 1'b1;
        end
      end else begin
        stop_scan = 1'b1;
      end
    end
    if (i_squash) deq_vld = '0;
  end

  always_comb begin
    n_enq = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      n_enq = n_enq + CW'(i_enq_req[k]);
    end
    if (!do_enq) n_enq = '0;
  end

  always_comb begin
    n_deq = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      n_deq = n_deq + CW'(deq_vld[i]);
    end
    if (!i_deq_req) n_deq = '0;
  end

  assign count_next = count_reg + n_enq - n_deq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else if (i_squash) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_reg + n_deq[PW-1:0];
      wptr_reg  <= wptr_reg + n_enq[PW-1:0];
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (do_enq && i_enq_req[k]) begin
        mem[wptr_reg + PW'(k)] <= i_enq_inst[k];
      end
    end
  end

  assign o_deq_vld  = deq_vld;
  assign o_deq_inst = head_entry;
  assign o_count    = count_reg;

  // Requests must be a run of ones starting at bit 0.
  a_enq_contiguous : assert property (@(posedge clk) disable iff (rst)
    ((i_enq_req & (i_enq_req + ENQ_WIDTH'(1))) == '0));

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    (count_reg <= CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Testbench for fetch_inst_buffer: directed groups plus a short random run.
// The monitor keeps a queue of expected entries and checks occupancy,
// valid pattern and head payloads on every falling edge.
module tb_fetch_inst_buffer;
  import fetch_inst_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic i_squash;
  logic [3:0] i_enq_req;
  fetch_entry_t [3:0] i_enq_inst;
  logic o_can_enq;
  logic [3:0] o_deq_vld;
  fetch_entry_t [3:0] o_deq_inst;
  logic i_deq_req;
  logic [4:0] o_count;

  int n_checks = 0;
  int n_pass   = 0;
  fetch_entry_t q[$];
  logic [31:0] next_inst = 32'h4000;

  always #5 clk = ~clk;

  fetch_inst_buffer #(.DEPTH(16), .ENQ_WIDTH(4), .DEQ_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_squash(i_squash), .i_enq_req(i_enq_req),
    .i_enq_inst(i_enq_inst), .o_can_enq(o_can_enq), .o_deq_vld(o_deq_vld),
    .o_deq_inst(o_deq_inst), .i_deq_req(i_deq_req), .o_count(o_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] base, input int k, input logic exc);
    fetch_entry_t e;
    e.inst       = base + 32'(k) * 32'h80;
    e.ftq_idx    = 4'(k + 3);
    e.ftq_offset = 3'(k);
    e.has_except = exc;
    e.except     = exc ? 4'hd : 4'h0;
    return e;
  endfunction

  task automatic idle();
    i_enq_req  = '0;
    i_enq_inst = '0;
    i_deq_req  = 1'b0;
    i_squash   = 1'b0;
  endtask

  task automatic drive(input logic [3:0] req, input logic [31:0] base,
                       input logic [3:0] exc, input logic deq, input logic sq);
    for (int k = 0; k < 4; k++) i_enq_inst[k] = mk(base, k, exc[k]);
    i_enq_req = req;
    i_deq_req = deq;
    i_squash  = sq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor / scoreboard
  logic [3:0] ev;
  logic       stop;
  int         sz;
  int         npop;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_vld", 64'(o_deq_vld), 64'd0);
        q.delete();
      end else begin
        sz = q.size();
        check("count", 64'(o_count), 64'(sz));
        check("can_enq", 64'(o_can_enq), 64'(sz <= 12));
        ev = '0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!stop && i < sz) begin
            if (q[i].has_except) begin
              stop = 1'b1;
              if (i == 0) ev[i] = 1'b1;
            end else ev[i] = 1'b1;
          end else stop = 1'b1;
        end
        if (i_squash) ev = '0;
        check("deq_vld", 64'(o_deq_vld), 64'(ev));
        for (int i = 0; i < 4; i++) begin
          if (ev[i]) check($sformatf("slot%0d", i), 64'(o_deq_inst[i]), 64'(q[i]));
        end
        if (i_squash) q.delete();
        else begin
          npop = 0;
          for (int i = 0; i < 4; i++) npop += int'(ev[i]);
          if (i_deq_req) for (int i = 0; i < npop; i++) void'(q.pop_front());
          if (sz <= 12)
            for (int k = 0; k < 4; k++) if (i_enq_req[k]) q.push_back(i_enq_inst[k]);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    idle();
    // 1: reset held across edges
    repeat (2) @(posedge clk);
    #1;
    check("t1_vld", 64'(o_deq_vld), 64'd0);
    check("t1_can_enq", 64'(o_can_enq), 64'd1);
    check("t1_count", 64'(o_count), 64'd0);
    rst = 1'b0;

    // 2: one full group, visible next cycle, then consumed
    drive(4'b1111, 32'h13, 4'b0000, 1'b0, 1'b0);
    step();
    check("t2_vld", 64'(o_deq_vld), 64'hf);
    check("t2_i0", 64'(o_deq_inst[0].inst), 64'h13);
    check("t2_i1", 64'(o_deq_inst[1].inst), 64'h93);
    check("t2_i2", 64'(o_deq_inst[2].inst), 64'h113);
    check("t2_i3", 64'(o_deq_inst[3].inst), 64'h193);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
    step();
    check("t2_count", 64'(o_count), 64'd0);

    // 3: fill to 16, fifth group dropped
    for (int g = 0; g < 4; g++) begin
      drive(4'b1111, 32'h13 + 32'(g) * 32'h200, 4'b0000, 1'b0, 1'b0);
      step();
    end
    check("t3_count_full", 64'(o_count), 64'd16);
    check("t3_can_enq", 64'(o_can_enq), 64'd0);
    drive(4'b1111, 32'h813, 4'b0000, 1'b0, 1'b0);
    step();
    check("t3_count_drop", 64'(o_count), 64'd16);
    check("t3_head", 64'(o_deq_inst[0].inst), 64'h13);
    repeat (4) begin
      drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
      step();
    end
    check("t3_drained", 64'(o_count), 64'd0);

    // 5: squash with simultaneous enq and deq
    drive(4'b1111, 32'h3000, 4'b0000, 1'b0, 1'b0);
    step();
    drive(4'b1111, 32'h3200, 4'b0000, 1'b0, 1'b0);
    step();
    check("t5_count8", 64'(o_count), 64'd8);
    drive(4'b1111, 32'h5000, 4'b0000, 1'b1, 1'b1);
    #1;
    check("t5_vld_gated", 64'(o_deq_vld), 64'd0);
    @(posedge clk);
    #1;
    idle();
    check("t5_count", 64'(o_count), 64'd0);
    check("t5_can_enq", 64'(o_can_enq), 64'd1);
    check("t5_vld", 64'(o_deq_vld), 64'd0);
    step();

    // 6: exception isolation
    drive(4'b1111, 32'ha00, 4'b0010, 1'b0, 1'b0);
    step();
    check("t6_vld_a", 64'(o_deq_vld), 64'h1);
    check("t6_inst_a", 64'(o_deq_inst[0].inst), 64'ha00);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
    step();
    check("t6_vld_b", 64'(o_deq_vld), 64'h1);
    check("t6_inst_b", 64'(o_deq_inst[0].inst), 64'ha80);
    check("t6_exc_b", 64'(o_deq_inst[0].has_except), 64'd1);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
    step();
    check("t6_vld_cd", 64'(o_deq_vld), 64'h3);
    check("t6_inst_c", 64'(o_deq_inst[0].inst), 64'hb00);
    check("t6_inst_d", 64'(o_deq_inst[1].inst), 64'hb80);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
    step();
    check("t6_count", 64'(o_count), 64'd0);

    // Asynchronous reset mid-operation clears immediately
    drive(4'b1111, 32'h900, 4'b0000, 1'b0, 1'b0);
    step();
    check("ar_count4", 64'(o_count), 64'd4);
    rst = 1'b1;
    #1;
    check("ar_count", 64'(o_count), 64'd0);
    check("ar_vld", 64'(o_deq_vld), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ar_can_enq", 64'(o_can_enq), 64'd1);

    // 4: random contiguous groups and random dequeue
    for (int c = 0; c < 50; c++) begin
      n = int'($urandom_range(0, 4));
      drive(4'((1 << n) - 1), next_inst, 4'b0000, 1'($urandom_range(0, 1)), 1'b0);
      next_inst = next_inst + 32'h200;
      step();
    end
    for (int t = 0; t < 20 && o_count != 0; t++) begin
      drive(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b0);
      step();
    end
    check("t4_drained", 64'(o_count), 64'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
